// File: rtl/dlf_pi.sv
// Gear-shifted PI loop filter: TDC phase error in, DCO tuning code out, with lock detection.
// Define DLF_PI_DITHER_EN to add first-order noise-shaped dithering of the code truncation.
module dlf_pi #(
  parameter int TDC_W         = 8,
  parameter int DCO_W         = 10,
  parameter int FRAC_W        = 8,
  parameter int DCO_INIT      = 512,
  parameter int KP_ACQ_SHIFT  = 1,
  parameter int KI_ACQ_SHIFT  = 3,
  parameter int KP_TRK_SHIFT  = 3,
  parameter int KI_TRK_SHIFT  = 6,
  parameter int LOCK_THRESH   = 2,
  parameter int LOCK_COUNT    = 16,
  parameter int UNLOCK_THRESH = 16,
  parameter int UNLOCK_COUNT  = 4
) (
  input  logic                    refclk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    tdc_valid,
  input  logic signed [TDC_W-1:0] tdc_in,
  output logic [DCO_W-1:0]        dco_code,
  output logic                    dco_valid,
  output logic                    locked,
  output logic [1:0]              mode
);
  localparam int IW   = DCO_W + FRAC_W + 2;
  localparam int LC_W = $clog2(LOCK_COUNT + 1);
  localparam int UC_W = $clog2(UNLOCK_COUNT + 1);
  localparam logic signed [IW-1:0] I_MAX  = IW'((64'(1) << (DCO_W + FRAC_W)) - 64'(1));
  localparam logic signed [IW-1:0] I_INIT = IW'(64'(DCO_INIT) << FRAC_W);

  typedef enum logic [1:0] {IDLE = 2'd0, ACQ = 2'd1, TRACK = 2'd2} state_t;

  state_t                 state;
  logic signed [IW-1:0]   integ, e_sh, ei, ep, integ_n, sum;
  logic [TDC_W:0]         ext, mag;
  logic                   in_lock, out_lock, lock_hit, unlock_hit;
  logic [LC_W-1:0]        lock_cnt, lock_nxt;
  logic [UC_W-1:0]        unlock_cnt, unlock_nxt;
  logic [DCO_W-1:0]       code_n;
  logic                   unused_bits;

  function automatic logic signed [IW-1:0] sat(input logic signed [IW-1:0] v);
    if (v < 0)          return '0;
    else if (v > I_MAX) return I_MAX;
    else                return v;
  endfunction

  always_comb begin
    e_sh    = {{(IW-TDC_W){tdc_in[TDC_W-1]}}, tdc_in} <<< FRAC_W;
    ei      = (state == TRACK) ? (e_sh >>> KI_TRK_SHIFT) : (e_sh >>> KI_ACQ_SHIFT);
    ep      = (state == TRACK) ? (e_sh >>> KP_TRK_SHIFT) : (e_sh >>> KP_ACQ_SHIFT);
    integ_n = sat(integ + ei);
    sum     = sat(integ_n + ep);
  end

  // Magnitude one bit wider so the most negative TDC code stays positive.
  always_comb begin
    ext        = {tdc_in[TDC_W-1], tdc_in};
    mag        = tdc_in[TDC_W-1] ? (~ext + 1'b1) : ext;
    in_lock    = mag <= (TDC_W+1)'(LOCK_THRESH);
    out_lock   = mag >  (TDC_W+1)'(UNLOCK_THRESH);
    lock_hit   = in_lock && (lock_cnt >= LC_W'(LOCK_COUNT - 1));
    lock_nxt   = !in_lock ? '0 : (lock_cnt == LC_W'(LOCK_COUNT)) ? lock_cnt : lock_cnt + 1'b1;
    unlock_hit = out_lock && (unlock_cnt >= UC_W'(UNLOCK_COUNT - 1));
    unlock_nxt = out_lock ? unlock_cnt + 1'b1 : '0;
  end

`ifdef DLF_PI_DITHER_EN
  logic [FRAC_W-1:0]    resid;
  logic signed [IW-1:0] t;
  always_comb begin
    t = sum + $signed({{(IW-FRAC_W){1'b0}}, resid});
    if (t > I_MAX) t = I_MAX;
    code_n = t[FRAC_W +: DCO_W];
  end
  assign unused_bits = ^t[IW-1:IW-2];

  always_ff @(posedge refclk or posedge reset)
    if (reset)                                            resid <= '0;
    else if (enable && tdc_valid && (state == ACQ || state == TRACK)) resid <= t[FRAC_W-1:0];
`else
  assign code_n      = sum[FRAC_W +: DCO_W];
  assign unused_bits = ^{sum[IW-1:IW-2], sum[FRAC_W-1:0]};
`endif

  assign mode = 2'(state);

  always_ff @(posedge refclk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      integ      <= I_INIT;
      dco_code   <= DCO_W'(DCO_INIT);
      dco_valid  <= 1'b0;
      locked     <= 1'b0;
      lock_cnt   <= '0;
      unlock_cnt <= '0;
    end else begin
      dco_valid <= 1'b0;
      if (!enable) begin
        state      <= IDLE;
        integ      <= I_INIT;
        dco_code   <= DCO_W'(DCO_INIT);
        locked     <= 1'b0;
        lock_cnt   <= '0;
        unlock_cnt <= '0;
      end else begin
        case (state)
          IDLE: state <= ACQ;
          ACQ, TRACK: if (tdc_valid) begin
            integ     <= integ_n;
            dco_code  <= code_n;
            dco_valid <= 1'b1;
            if (state == ACQ) begin
              if (lock_hit) begin
                state      <= TRACK;
                locked     <= 1'b1;
                lock_cnt   <= '0;
                unlock_cnt <= '0;
              end else lock_cnt <= lock_nxt;
            end else begin
              if (unlock_hit) begin
                state      <= ACQ;
                locked     <= 1'b0;
                lock_cnt   <= '0;
                unlock_cnt <= '0;
              end else unlock_cnt <= unlock_nxt;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_dlf_pi.sv
// Randomized bench for dlf_pi against an integer-arithmetic reference model, plus literal anchors.
module tb_dlf_pi;
  localparam int MAXV = (1 << 18) - 1;
  localparam int INIT = 512 << 8;

  logic              refclk = 0;
  logic              reset = 1;
  logic              enable = 0;
  logic              tdc_valid = 0;
  logic signed [7:0] tdc_in = 0;
  logic [9:0]        dco_code;
  logic              dco_valid, locked;
  logic [1:0]        mode;

  dlf_pi dut (
    .refclk(refclk), .reset(reset), .enable(enable), .tdc_valid(tdc_valid), .tdc_in(tdc_in),
    .dco_code(dco_code), .dco_valid(dco_valid), .locked(locked), .mode(mode)
  );

  always #5 refclk = ~refclk;

  int n_cmp = 0, n_bad = 0;

  // Reference model: mode 0/1/2, integrator and counters as plain ints.
  int m_mode = 0, m_integ = INIT, m_code = 512, m_valid = 0, m_lc = 0, m_uc = 0, m_resid = 0;

  function automatic int clampi(input int v);
    return (v < 0) ? 0 : (v > MAXV) ? MAXV : v;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_integ = INIT; m_code = 512; m_valid = 0; m_lc = 0; m_uc = 0; m_resid = 0;
  endtask

  task automatic model_step();
    int e, a, s, ki, kp;
    m_valid = 0;
    if (!enable) begin
      m_mode = 0; m_integ = INIT; m_code = 512; m_lc = 0; m_uc = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (tdc_valid) begin
      e  = int'(tdc_in);
      ki = (m_mode == 2) ? 6 : 3;
      kp = (m_mode == 2) ? 3 : 1;
      m_integ = clampi(m_integ + ((e * 256) >>> ki));
      s = clampi(m_integ + ((e * 256) >>> kp));
`ifdef DLF_PI_DITHER_EN
      s = s + m_resid;
      if (s > MAXV) s = MAXV;
      m_resid = s % 256;
`endif
      m_code  = s / 256;
      m_valid = 1;
      a = (e < 0) ? -e : e;
      if (m_mode == 1) begin
        m_lc = (a <= 2) ? m_lc + 1 : 0;
        if (m_lc >= 16) begin m_mode = 2; m_lc = 0; m_uc = 0; end
      end else begin
        m_uc = (a > 16) ? m_uc + 1 : 0;
        if (m_uc >= 4) begin m_mode = 1; m_lc = 0; m_uc = 0; end
      end
    end
  endtask

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Single compare process: advance model on every edge, then check all outputs.
  always begin
    @(posedge refclk or posedge reset);
    if (reset) model_reset(); else model_step();
    #1;
    cmp("dco_code", int'(dco_code), m_code);
    cmp("dco_valid", int'(dco_valid), m_valid);
    cmp("locked", int'(locked), (m_mode == 2) ? 1 : 0);
    cmp("mode", int'(mode), m_mode);
  end

  task automatic cyc(input logic en, input logic v, input int d);
    enable = en; tdc_valid = v; tdc_in = 8'(d);
    @(posedge refclk); #2;
  endtask

  int d, seg_small;

  initial begin
    repeat (3) cyc(0, 0, 0);
    cmp("rst_code", int'(dco_code), 512);
    cmp("rst_mode", int'(mode), 0);
    cmp("rst_locked", int'(locked), 0);
    reset = 0;
    cyc(1, 0, 0);
    cmp("idle_to_acq", int'(mode), 1);
    cmp("first_code", int'(dco_code), 512);
    cyc(1, 1, 8);
    cmp("p8_first", int'(dco_code), 517);
    cmp("p8_valid", int'(dco_valid), 1);
    cyc(1, 1, 8);
    cmp("p8_second", int'(dco_code), 518);
    cyc(1, 0, 0);
    cmp("hold_valid", int'(dco_valid), 0);
    cmp("hold_code", int'(dco_code), 518);

    // Lock acquisition with one restart at sample 10.
    for (int i = 1; i <= 26; i++) begin
      cyc(1, 1, (i == 10) ? 3 : 0);
      if (i == 25) cmp("lock_pre", int'(locked), 0);
    end
    cmp("lock_at26", int'(locked), 1);
    cmp("lock_mode", int'(mode), 2);

    repeat (3) cyc(1, 1, 20);
    cyc(1, 1, 0);
    cmp("trk_hold", int'(locked), 1);
    repeat (4) cyc(1, 1, 20);
    cmp("unlock_locked", int'(locked), 0);
    cmp("unlock_mode", int'(mode), 1);

    cyc(0, 1, 50);
    cmp("dis_mode", int'(mode), 0);
    cmp("dis_code", int'(dco_code), 512);
    cyc(0, 1, 50);
    cmp("dis_valid", int'(dco_valid), 0);

    cyc(1, 0, 0);
    repeat (100) cyc(1, 1, 64);
    cmp("sat_hi", int'(dco_code), 1023);
    repeat (200) cyc(1, 1, -64);
    cmp("sat_lo", int'(dco_code), 0);
    repeat (3) cyc(1, 1, -128);
    cmp("min_in", int'(dco_code), 0);

    repeat (5) cyc(1, 1, 40);
    #3 reset = 1;
    #1 cmp("arst_code", int'(dco_code), 512);
    cmp("arst_locked", int'(locked), 0);
    @(posedge refclk); #2;
    reset = 0;

    // Randomized segments alternating lock-friendly and noisy error streams.
    for (int seg = 0; seg < 40; seg++) begin
      seg_small = (seg % 2 == 0) ? 97 : 40;
      for (int k = 0; k < 80; k++) begin
        if ($urandom_range(99) < seg_small) d = $urandom_range(4) - 2;
        else if ($urandom_range(1) == 0)     d = $urandom_range(60) - 30;
        else                                 d = $urandom_range(255) - 128;
        if ($urandom_range(299) == 0) begin
          #3 reset = 1;
          @(posedge refclk); #2;
          reset = 0;
        end
        cyc($urandom_range(199) != 0, $urandom_range(9) < 8, d);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
